// File: rtl/pkt_builder.sv
// Packet builder: writes header, payload and CRC8 of one packet through a registered byte port.
// Optional build macro PB_ECC_ERR_INJECT_EN adds header bit-flip injection inputs.
module pkt_builder #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MEM_DEPTH = 16384,
  parameter logic [2:0]  SOP_MARK  = 3'b111,
  parameter logic [7:0]  CRC_POLY  = 8'h07
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_addr_hdr,
  input  logic [3:0]        cfg_pkt_type,
  input  logic [3:0]        cfg_byte_cnt,
  input  logic              pl_valid,
  input  logic [7:0]        pl_data,
  output logic              pl_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              irq,
`ifdef PB_ECC_ERR_INJECT_EN
  input  logic [1:0]        inj_en,
  input  logic [3:0]        inj_bit0,
  input  logic [3:0]        inj_bit1,
`endif
  output logic              cfg_err
);

  typedef enum logic [2:0] {
    StIdle,
    StHdrLo,
    StHdrHi,
    StData,
    StCrc,
    StDone
  } state_e;

  localparam logic [ADDR_W:0] LastAddr = (ADDR_W+1)'(MEM_DEPTH - 1);

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  // Hamming-style check nibble plus overall parity over {type, count}.
  function automatic logic [15:0] hdr_calc(input logic [3:0] pkt_type,
                                           input logic [3:0] byte_cnt);
    logic [7:0] d;
    logic [3:0] e;
    d    = {pkt_type, byte_cnt};
    e[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    e[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    e[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    e[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {SOP_MARK, ^d, d, e};
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          bc_q, bc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         hdr_q, hdr_d;
  logic [7:0]          crc_q, crc_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                irq_q, irq_d;
  logic                cfg_err_q, cfg_err_d;

  logic [ADDR_W:0]     end_addr;
  logic                range_bad;
  logic [11:0]         inj_mask;

  // Last byte address computed one bit wider so wrap-around cannot hide an overflow.
  assign end_addr  = {1'b0, cfg_addr_hdr} + (ADDR_W+1)'(cfg_byte_cnt) + (ADDR_W+1)'(3);
  assign range_bad = end_addr > LastAddr;

`ifdef PB_ECC_ERR_INJECT_EN
  always_comb begin
    inj_mask = '0;
    for (int i = 0; i < 12; i++) begin
      if ((inj_en == 2'b01 || inj_en == 2'b10) && inj_bit0 == 4'(i)) inj_mask[i] = 1'b1;
      if (inj_en == 2'b10 && inj_bit1 == 4'(i)) inj_mask[i] = 1'b1;
    end
  end
`else
  assign inj_mask = '0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bc_d        = bc_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    crc_d       = crc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    irq_d       = 1'b0;
    cfg_err_d   = 1'b0;
    pl_ready    = (state_q == StData);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (range_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            addr_d  = cfg_addr_hdr;
            bc_d    = cfg_byte_cnt;
            cnt_d   = 4'd0;
            hdr_d   = hdr_calc(cfg_pkt_type, cfg_byte_cnt) ^ {4'b0, inj_mask};
            crc_d   = 8'h00;
            busy_d  = 1'b1;
            state_d = StHdrLo;
          end
        end
      end
      StHdrLo: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = hdr_q[7:0];
        addr_d      = addr_q + ADDR_W'(1);
        state_d     = StHdrHi;
      end
      StHdrHi: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = hdr_q[15:8];
        addr_d      = addr_q + ADDR_W'(1);
        state_d     = StData;
      end
      StData: begin
        if (pl_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = pl_data;
          addr_d      = addr_q + ADDR_W'(1);
          crc_d       = crc8_step(crc_q, pl_data);
          cnt_d       = cnt_q + 4'd1;
          if (cnt_q == bc_q) state_d = StCrc;
        end
      end
      StCrc: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = crc_q;
        irq_d       = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      bc_q        <= '0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      crc_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bc_q        <= bc_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      crc_q       <= crc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      irq_q       <= irq_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign irq       = irq_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pkt_builder.sv
// Directed bench for pkt_builder: byte memory model plus hand-computed packet images.
module tb_pkt_builder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] cfg_addr_hdr;
  logic [3:0]  cfg_pkt_type;
  logic [3:0]  cfg_byte_cnt;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_ready;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        irq;
  logic        cfg_err;
`ifdef PB_ECC_ERR_INJECT_EN
  logic [1:0]  inj_en;
  logic [3:0]  inj_bit0;
  logic [3:0]  inj_bit1;
`endif

  logic [7:0]  mem [0:16383];
  logic [7:0]  pl_buf [0:15];
  int          wr_cnt = 0;
  int          checks = 0;
  int          fails = 0;
  int          lat;
  int          wr0;

  always #5 clk = ~clk;

  pkt_builder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_addr_hdr (cfg_addr_hdr),
    .cfg_pkt_type (cfg_pkt_type),
    .cfg_byte_cnt (cfg_byte_cnt),
    .pl_valid     (pl_valid),
    .pl_data      (pl_data),
    .pl_ready     (pl_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .irq          (irq),
`ifdef PB_ECC_ERR_INJECT_EN
    .inj_en       (inj_en),
    .inj_bit0     (inj_bit0),
    .inj_bit1     (inj_bit1),
`endif
    .cfg_err      (cfg_err)
  );

  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one start, feeds pl_buf, returns the edge count from the sampling edge to irq.
  task automatic run_pkt(input logic [13:0] a, input logic [3:0] t, input logic [3:0] bc,
                         input bit gappy, input int abort_after, output int lat_o);
    int  k;
    int  cyc;
    bit  tog;
    bit  hs;
    bit  aborted;
    cfg_addr_hdr = a;
    cfg_pkt_type = t;
    cfg_byte_cnt = bc;
    start        = 1'b1;
    pl_valid     = 1'b0;
    step();
    start        = 1'b0;
    cfg_addr_hdr = ~a;
    cfg_pkt_type = ~t;
    cfg_byte_cnt = ~bc;
    chk("busy_after_start", busy, 1);
    cyc     = 1;
    k       = 0;
    tog     = 1'b1;
    aborted = 1'b0;
    lat_o   = -1;
    while (cyc < 60 && lat_o < 0 && !aborted) begin
      if (irq) begin
        lat_o = cyc;
      end else if (abort_after >= 0 && k == abort_after) begin
        reset    = 1'b1;
        pl_valid = 1'b0;
        step();
        reset    = 1'b0;
        aborted  = 1'b1;
      end else begin
        if (pl_ready && k <= int'(bc)) begin
          pl_valid = gappy ? tog : 1'b1;
          pl_data  = pl_buf[k];
          tog      = ~tog;
        end else begin
          pl_valid = 1'b0;
        end
        hs = pl_valid && pl_ready;
        step();
        cyc++;
        if (hs) k++;
      end
    end
    pl_valid = 1'b0;
    if (lat_o >= 0) begin
      step();
      chk("irq_one_cycle", irq, 0);
      chk("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    cfg_addr_hdr = '0;
    cfg_pkt_type = '0;
    cfg_byte_cnt = '0;
    pl_valid     = 1'b0;
    pl_data      = '0;
`ifdef PB_ECC_ERR_INJECT_EN
    inj_en   = 2'b00;
    inj_bit0 = 4'd0;
    inj_bit1 = 4'd0;
`endif
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pl_ready", pl_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // Type A, BC=3 at 0x100: header EA30, CRC of 00..03 is 48.
    for (int i = 0; i < 4; i++) pl_buf[i] = 8'(i);
    wr0 = wr_cnt;
    run_pkt(14'h100, 4'hA, 4'd3, 1'b0, -1, lat);
    step();
    chk("t1_latency", lat, 8);
    chk("t1_hdr_lo", mem[14'h100], 8'h30);
    chk("t1_hdr_hi", mem[14'h101], 8'hEA);
    chk("t1_pl0", mem[14'h102], 8'h00);
    chk("t1_pl3", mem[14'h105], 8'h03);
    chk("t1_crc", mem[14'h106], 8'h48);
    chk("t1_writes", wr_cnt - wr0, 7);

    // BC=0, single byte 01 -> CRC 07; header F109.
    pl_buf[0] = 8'h01;
    run_pkt(14'h000, 4'h1, 4'd0, 1'b0, -1, lat);
    step();
    chk("t2_latency", lat, 5);
    chk("t2_hdr_lo", mem[14'h000], 8'h09);
    chk("t2_hdr_hi", mem[14'h001], 8'hF1);
    chk("t2_pl0", mem[14'h002], 8'h01);
    chk("t2_crc", mem[14'h003], 8'h07);

    // BC=8, "123456789" -> CRC F4; header E28D.
    for (int i = 0; i < 9; i++) pl_buf[i] = 8'h31 + 8'(i);
    run_pkt(14'h1000, 4'h2, 4'd8, 1'b0, -1, lat);
    step();
    chk("t3_latency", lat, 13);
    chk("t3_hdr_lo", mem[14'h1000], 8'h8D);
    chk("t3_hdr_hi", mem[14'h1001], 8'hE2);
    chk("t3_pl0", mem[14'h1002], 8'h31);
    chk("t3_pl8", mem[14'h100A], 8'h39);
    chk("t3_crc", mem[14'h100B], 8'hF4);

    // Gapped payload 1,0,1,0,...: three idle cycles added; header E534.
    for (int i = 0; i < 4; i++) pl_buf[i] = 8'(i);
    wr0 = wr_cnt;
    run_pkt(14'h200, 4'h5, 4'd3, 1'b1, -1, lat);
    step();
    chk("t4_latency", lat, 11);
    chk("t4_hdr_lo", mem[14'h200], 8'h34);
    chk("t4_hdr_hi", mem[14'h201], 8'hE5);
    chk("t4_pl1", mem[14'h203], 8'h01);
    chk("t4_pl2", mem[14'h204], 8'h02);
    chk("t4_crc", mem[14'h206], 8'h48);
    chk("t4_writes", wr_cnt - wr0, 7);

    // Out of range: 0x3FFC + 1 + 3 = 0x4000.
    wr0          = wr_cnt;
    cfg_addr_hdr = 14'h3FFC;
    cfg_pkt_type = 4'h0;
    cfg_byte_cnt = 4'd1;
    start        = 1'b1;
    step();
    start = 1'b0;
    chk("t5_cfg_err", cfg_err, 1);
    chk("t5_busy", busy, 0);
    step();
    chk("t5_cfg_err_pulse", cfg_err, 0);
    chk("t5_busy_stays", busy, 0);
    step();
    chk("t5_no_writes", wr_cnt - wr0, 0);

    // Last legal placement ends exactly at 0x3FFF; header F013.
    pl_buf[0] = 8'h00;
    pl_buf[1] = 8'h01;
    run_pkt(14'h3FFB, 4'h0, 4'd1, 1'b0, -1, lat);
    step();
    chk("t6_latency", lat, 6);
    chk("t6_hdr_lo", mem[14'h3FFB], 8'h13);
    chk("t6_hdr_hi", mem[14'h3FFC], 8'hF0);
    chk("t6_crc", mem[14'h3FFF], 8'h07);

    // Reset after two payload bytes: outputs clear, written bytes remain.
    for (int i = 0; i < 4; i++) pl_buf[i] = 8'(i);
    wr0 = wr_cnt;
    run_pkt(14'h300, 4'hA, 4'd3, 1'b0, 2, lat);
    chk("t7_mem_we", mem_we, 0);
    chk("t7_busy", busy, 0);
    chk("t7_pl_ready", pl_ready, 0);
    chk("t7_irq", irq, 0);
    chk("t7_mem_addr", mem_addr, 0);
    repeat (4) step();
    chk("t7_irq_later", irq, 0);
    chk("t7_writes", wr_cnt - wr0, 4);
    chk("t7_hdr_lo", mem[14'h300], 8'h30);
    chk("t7_pl1", mem[14'h303], 8'h01);

    wr0 = wr_cnt;
    run_pkt(14'h400, 4'hA, 4'd3, 1'b0, -1, lat);
    step();
    chk("t8_latency", lat, 8);
    chk("t8_hdr_hi", mem[14'h401], 8'hEA);
    chk("t8_crc", mem[14'h406], 8'h48);
    chk("t8_writes", wr_cnt - wr0, 7);

`ifdef PB_ECC_ERR_INJECT_EN
    inj_en   = 2'b01;
    inj_bit0 = 4'd5;
    run_pkt(14'h500, 4'hA, 4'd3, 1'b0, -1, lat);
    step();
    chk("inj_single", mem[14'h500], 8'h10);
    inj_en   = 2'b10;
    inj_bit0 = 4'd0;
    inj_bit1 = 4'd1;
    run_pkt(14'h600, 4'hA, 4'd3, 1'b0, -1, lat);
    step();
    chk("inj_double", mem[14'h600], 8'h33);
    inj_en = 2'b00;
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
